// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use hazard
// detection and ALU operand selection.
//
// Pipeline handshake: an instruction in ID advances into this stage on a
// rising clk unless i_stall holds the stage or a load-use hazard inserts a
// bubble. i_flush overrides everything and kills the stage contents. While
// o_stall_id is high, ID must keep presenting the same instruction; it is
// accepted on the edge after the bubble.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic [31:0] i_rs_data,
    input  logic [31:0] i_rt_data,
    input  logic [31:0] i_imm,
    input  logic [4:0]  i_shamt,
    input  logic [4:0]  i_rs_addr,
    input  logic [4:0]  i_rt_addr,
    input  logic [4:0]  i_wr_addr,
    input  logic [3:0]  i_operation,
    input  logic        i_alu_src,
    input  logic        i_reg_write,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic        i_exmem_reg_write,
    input  logic [4:0]  i_exmem_rd,
    input  logic [31:0] i_exmem_res,
    input  logic        i_memwb_reg_write,
    input  logic [4:0]  i_memwb_rd,
    input  logic [31:0] i_memwb_res,
    output logic [31:0] o_A,
    output logic [31:0] o_B,
    output logic [3:0]  o_operation,
    output logic [31:0] o_store_data,
    output logic [4:0]  o_wr_addr,
    output logic        o_valid,
    output logic        o_reg_write,
    output logic        o_mem_read,
    output logic        o_mem_write,
    output logic        o_stall_id
);

    localparam logic [3:0] OP_SLL = 4'b0111;
    localparam logic [3:0] OP_SRL = 4'b1000;
    localparam logic [3:0] OP_SRA = 4'b1001;
    localparam logic [3:0] OP_LUI = 4'b1101;

    logic        r_valid;
    logic        r_reg_write;
    logic        r_mem_read;
    logic        r_mem_write;
    logic        r_alu_src;
    logic [3:0]  r_operation;
    logic [31:0] r_rs_data;
    logic [31:0] r_rt_data;
    logic [31:0] r_imm;
    logic [4:0]  r_shamt;
    logic [4:0]  r_rs_addr;
    logic [4:0]  r_rt_addr;
    logic [4:0]  r_wr_addr;

    logic        w_hazard;
    logic [31:0] w_fa;
    logic [31:0] w_fb;
    logic        w_is_shift;

    // Load-use hazard: a valid load here writes a register ID is reading.
    always_comb begin
        w_hazard = r_valid && r_mem_read && (r_wr_addr != 5'd0) &&
                   ((r_wr_addr == i_rs_addr) || (r_wr_addr == i_rt_addr));
        o_stall_id = w_hazard && !i_flush;
    end

    // Stage register: flush beats stall, stall beats bubble, bubble beats load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_alu_src   <= 1'b0;
            r_operation <= 4'b0000;
            r_rs_data   <= 32'd0;
            r_rt_data   <= 32'd0;
            r_imm       <= 32'd0;
            r_shamt     <= 5'd0;
            r_rs_addr   <= 5'd0;
            r_rt_addr   <= 5'd0;
            r_wr_addr   <= 5'd0;
        end else if (i_flush || (!i_stall && w_hazard)) begin
            // Bubble: kill control only, data fields are left as they were.
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_alu_src   <= 1'b0;
            r_operation <= 4'b0000;
        end else if (!i_stall) begin
            r_valid     <= i_valid;
            r_reg_write <= i_valid && i_reg_write;
            r_mem_read  <= i_valid && i_mem_read;
            r_mem_write <= i_valid && i_mem_write;
            r_alu_src   <= i_alu_src;
            r_operation <= i_operation;
            r_rs_data   <= i_rs_data;
            r_rt_data   <= i_rt_data;
            r_imm       <= i_imm;
            r_shamt     <= i_shamt;
            r_rs_addr   <= i_rs_addr;
            r_rt_addr   <= i_rt_addr;
            r_wr_addr   <= i_wr_addr;
        end
    end

    // Forwarding muxes: EX/MEM is newest so it wins; r0 is never forwarded.
    always_comb begin
        w_fa = r_rs_data;
        w_fb = r_rt_data;
        if (i_exmem_reg_write && (i_exmem_rd != 5'd0) && (i_exmem_rd == r_rs_addr))
            w_fa = i_exmem_res;
        else if (i_memwb_reg_write && (i_memwb_rd != 5'd0) && (i_memwb_rd == r_rs_addr))
            w_fa = i_memwb_res;
        if (i_exmem_reg_write && (i_exmem_rd != 5'd0) && (i_exmem_rd == r_rt_addr))
            w_fb = i_exmem_res;
        else if (i_memwb_reg_write && (i_memwb_rd != 5'd0) && (i_memwb_rd == r_rt_addr))
            w_fb = i_memwb_res;
    end

    // ALU operand selection: shifts take shamt on A, imm/LUI take imm on B.
    always_comb begin
        w_is_shift   = (r_operation == OP_SLL) || (r_operation == OP_SRL) ||
                       (r_operation == OP_SRA);
        o_A          = w_is_shift ? {27'd0, r_shamt} : w_fa;
        o_B          = (r_alu_src || (r_operation == OP_LUI)) ? r_imm : w_fb;
        o_store_data = w_fb;
    end

    assign o_operation = r_operation;
    assign o_wr_addr   = r_wr_addr;
    assign o_valid     = r_valid;
    assign o_reg_write = r_reg_write;
    assign o_mem_read  = r_mem_read;
    assign o_mem_write = r_mem_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid, i_stall, i_flush;
    logic [31:0] i_rs_data, i_rt_data, i_imm;
    logic [4:0]  i_shamt, i_rs_addr, i_rt_addr, i_wr_addr;
    logic [3:0]  i_operation;
    logic        i_alu_src, i_reg_write, i_mem_read, i_mem_write;
    logic        i_exmem_reg_write, i_memwb_reg_write;
    logic [4:0]  i_exmem_rd, i_memwb_rd;
    logic [31:0] i_exmem_res, i_memwb_res;
    logic [31:0] o_A, o_B, o_store_data;
    logic [3:0]  o_operation;
    logic [4:0]  o_wr_addr;
    logic        o_valid, o_reg_write, o_mem_read, o_mem_write, o_stall_id;

    int n_vec = 0;
    int n_err = 0;

    // Clock
    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .i_stall(i_stall), .i_flush(i_flush),
        .i_rs_data(i_rs_data), .i_rt_data(i_rt_data), .i_imm(i_imm),
        .i_shamt(i_shamt), .i_rs_addr(i_rs_addr), .i_rt_addr(i_rt_addr),
        .i_wr_addr(i_wr_addr), .i_operation(i_operation), .i_alu_src(i_alu_src),
        .i_reg_write(i_reg_write), .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
        .i_exmem_reg_write(i_exmem_reg_write), .i_exmem_rd(i_exmem_rd),
        .i_exmem_res(i_exmem_res), .i_memwb_reg_write(i_memwb_reg_write),
        .i_memwb_rd(i_memwb_rd), .i_memwb_res(i_memwb_res),
        .o_A(o_A), .o_B(o_B), .o_operation(o_operation), .o_store_data(o_store_data),
        .o_wr_addr(o_wr_addr), .o_valid(o_valid), .o_reg_write(o_reg_write),
        .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_stall_id(o_stall_id)
    );

    // Move to 2ns after the next rising edge; inputs change only here.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        i_valid = 0; i_stall = 0; i_flush = 0;
        i_rs_data = 0; i_rt_data = 0; i_imm = 0; i_shamt = 0;
        i_rs_addr = 0; i_rt_addr = 0; i_wr_addr = 0; i_operation = 0;
        i_alu_src = 0; i_reg_write = 0; i_mem_read = 0; i_mem_write = 0;
        i_exmem_reg_write = 0; i_exmem_rd = 0; i_exmem_res = 0;
        i_memwb_reg_write = 0; i_memwb_rd = 0; i_memwb_res = 0;
    endtask

    task automatic drive_instr(input logic [31:0] rs_d, input logic [31:0] rt_d,
                               input logic [31:0] imm, input logic [4:0] shamt,
                               input logic [4:0] rs_a, input logic [4:0] rt_a,
                               input logic [4:0] wr_a, input logic [3:0] op,
                               input logic alu_src, input logic rw, input logic mr);
        i_valid = 1; i_rs_data = rs_d; i_rt_data = rt_d; i_imm = imm; i_shamt = shamt;
        i_rs_addr = rs_a; i_rt_addr = rt_a; i_wr_addr = wr_a; i_operation = op;
        i_alu_src = alu_src; i_reg_write = rw; i_mem_read = mr; i_mem_write = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 0;
        #3;
        n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b exp 0", o_valid); end
        n_vec++; if (o_operation !== 4'h0) begin n_err++; $display("FAIL reset_op got %h exp 0", o_operation); end
        n_vec++; if ({o_A, o_B, o_store_data} !== 96'd0) begin n_err++; $display("FAIL reset_data got %h %h %h exp 0", o_A, o_B, o_store_data); end
        n_vec++; if ({o_wr_addr, o_reg_write, o_mem_read, o_mem_write, o_stall_id} !== 9'd0) begin n_err++; $display("FAIL reset_ctrl got %h exp 0", {o_wr_addr, o_reg_write, o_mem_read, o_mem_write, o_stall_id}); end
        tick();
        rst = 1;
        tick();
    endtask

    task automatic test_add();
        idle_inputs();
        drive_instr(32'd1, 32'd5, 32'd0, 5'd0, 5'd1, 5'd2, 5'd9, 4'b0000, 0, 1, 0);
        tick();
        n_vec++; if (o_A !== 32'd1) begin n_err++; $display("FAIL add_A got %h exp 1", o_A); end
        n_vec++; if (o_B !== 32'd5) begin n_err++; $display("FAIL add_B got %h exp 5", o_B); end
        n_vec++; if (o_operation !== 4'b0000) begin n_err++; $display("FAIL add_op got %h exp 0", o_operation); end
        n_vec++; if ({o_valid, o_reg_write, o_wr_addr} !== {1'b1, 1'b1, 5'd9}) begin n_err++; $display("FAIL add_ctrl got %b%b %0d exp 11 9", o_valid, o_reg_write, o_wr_addr); end
        // invalid instruction: control bits captured as zero
        idle_inputs();
        i_reg_write = 1; i_mem_write = 1;
        tick();
        n_vec++; if ({o_valid, o_reg_write, o_mem_write} !== 3'b000) begin n_err++; $display("FAIL invalid_ctrl got %b exp 000", {o_valid, o_reg_write, o_mem_write}); end
    endtask

    task automatic test_shift_lui();
        idle_inputs();
        drive_instr(32'h55, 32'h1F, 32'h0, 5'd4, 5'd1, 5'd2, 5'd3, 4'b0111, 0, 1, 0);
        tick();
        n_vec++; if (o_A !== 32'h4) begin n_err++; $display("FAIL sll_A got %h exp 00000004", o_A); end
        n_vec++; if (o_B !== 32'h1F) begin n_err++; $display("FAIL sll_B got %h exp 0000001f", o_B); end
        drive_instr(32'h77, 32'h1F, 32'h0, 5'd2, 5'd1, 5'd2, 5'd3, 4'b1001, 0, 1, 0);
        tick();
        n_vec++; if (o_A !== 32'h2) begin n_err++; $display("FAIL sra_A got %h exp 00000002", o_A); end
        drive_instr(32'h0, 32'h33, 32'h1001, 5'd0, 5'd0, 5'd2, 5'd3, 4'b1101, 0, 1, 0);
        tick();
        n_vec++; if (o_B !== 32'h1001) begin n_err++; $display("FAIL lui_B got %h exp 00001001", o_B); end
        n_vec++; if (o_store_data !== 32'h33) begin n_err++; $display("FAIL lui_store got %h exp 00000033", o_store_data); end
        drive_instr(32'h8, 32'h33, 32'h20, 5'd0, 5'd1, 5'd2, 5'd3, 4'b0000, 1, 1, 0);
        tick();
        n_vec++; if (o_B !== 32'h20) begin n_err++; $display("FAIL imm_B got %h exp 00000020", o_B); end
    endtask

    task automatic test_forwarding();
        idle_inputs();
        drive_instr(32'h11, 32'h66, 32'h0, 5'd0, 5'd3, 5'd4, 5'd5, 4'b0000, 0, 1, 0);
        tick();
        i_stall = 1;
        i_exmem_reg_write = 1; i_exmem_rd = 3; i_exmem_res = 32'hAA;
        i_memwb_reg_write = 1; i_memwb_rd = 3; i_memwb_res = 32'hBB;
        #1;
        n_vec++; if (o_A !== 32'hAA) begin n_err++; $display("FAIL fwd_both got %h exp 000000aa", o_A); end
        n_vec++; if (o_B !== 32'h66) begin n_err++; $display("FAIL fwd_B_nomatch got %h exp 00000066", o_B); end
        i_exmem_reg_write = 0;
        #1;
        n_vec++; if (o_A !== 32'hBB) begin n_err++; $display("FAIL fwd_memwb got %h exp 000000bb", o_A); end
        i_memwb_reg_write = 0;
        #1;
        n_vec++; if (o_A !== 32'h11) begin n_err++; $display("FAIL fwd_none got %h exp 00000011", o_A); end
        i_exmem_reg_write = 1; i_exmem_rd = 4; i_exmem_res = 32'hCC;
        #1;
        n_vec++; if ({o_B, o_store_data} !== {32'hCC, 32'hCC}) begin n_err++; $display("FAIL fwd_rt got %h %h exp cc cc", o_B, o_store_data); end
        // rs = r0: forwarding from rd=0 must not take effect
        i_stall = 0;
        idle_inputs();
        drive_instr(32'h22, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 5'd5, 4'b0000, 0, 1, 0);
        tick();
        i_exmem_reg_write = 1; i_exmem_rd = 0; i_exmem_res = 32'hAA;
        i_memwb_reg_write = 1; i_memwb_rd = 0; i_memwb_res = 32'hBB;
        #1;
        n_vec++; if (o_A !== 32'h22) begin n_err++; $display("FAIL fwd_r0 got %h exp 00000022", o_A); end
        idle_inputs();
    endtask

    task automatic test_load_use();
        idle_inputs();
        // lw into r7
        drive_instr(32'h0, 32'h0, 32'h4, 5'd0, 5'd1, 5'd7, 5'd7, 4'b0000, 1, 1, 1);
        tick();
        n_vec++; if (o_mem_read !== 1'b1) begin n_err++; $display("FAIL lw_memread got %b exp 1", o_mem_read); end
        // dependent add: rt = r7
        drive_instr(32'h3, 32'h9, 32'h0, 5'd0, 5'd2, 5'd7, 5'd8, 4'b0000, 0, 1, 0);
        #1;
        n_vec++; if (o_stall_id !== 1'b1) begin n_err++; $display("FAIL lu_stall got %b exp 1", o_stall_id); end
        tick();
        n_vec++; if ({o_valid, o_reg_write, o_mem_read} !== 3'b000) begin n_err++; $display("FAIL lu_bubble got %b exp 000", {o_valid, o_reg_write, o_mem_read}); end
        n_vec++; if (o_stall_id !== 1'b0) begin n_err++; $display("FAIL lu_stall_clr got %b exp 0", o_stall_id); end
        tick();
        n_vec++; if ({o_valid, o_wr_addr, o_B} !== {1'b1, 5'd8, 32'h9}) begin n_err++; $display("FAIL lu_reload got %b %0d %h exp 1 8 00000009", o_valid, o_wr_addr, o_B); end
        // load targeting r0 never stalls
        drive_instr(32'h0, 32'h0, 32'h4, 5'd0, 5'd1, 5'd0, 5'd0, 4'b0000, 1, 1, 1);
        tick();
        drive_instr(32'h3, 32'h9, 32'h0, 5'd0, 5'd0, 5'd0, 5'd8, 4'b0000, 0, 1, 0);
        #1;
        n_vec++; if (o_stall_id !== 1'b0) begin n_err++; $display("FAIL lu_r0 got %b exp 0", o_stall_id); end
        tick();
    endtask

    task automatic test_flush_stall();
        idle_inputs();
        // lw into r6, then ID reads r6 (rs) while flush is asserted
        drive_instr(32'h0, 32'h0, 32'h4, 5'd0, 5'd1, 5'd2, 5'd6, 4'b0010, 1, 1, 1);
        tick();
        drive_instr(32'h1, 32'h2, 32'h0, 5'd0, 5'd6, 5'd3, 5'd4, 4'b0000, 0, 1, 0);
        i_flush = 1; i_stall = 1;
        #1;
        n_vec++; if (o_stall_id !== 1'b0) begin n_err++; $display("FAIL flush_stallid got %b exp 0", o_stall_id); end
        tick();
        n_vec++; if ({o_valid, o_reg_write, o_mem_read, o_mem_write, o_operation} !== 8'd0) begin n_err++; $display("FAIL flush_ctrl got %b exp 00000000", {o_valid, o_reg_write, o_mem_read, o_mem_write, o_operation}); end
        i_flush = 0; i_stall = 0;
        drive_instr(32'h40, 32'h50, 32'h0, 5'd0, 5'd10, 5'd11, 5'd12, 4'b0011, 0, 1, 0);
        tick();
        i_stall = 1;
        drive_instr(32'h99, 32'h98, 32'h97, 5'd1, 5'd13, 5'd14, 5'd15, 4'b0100, 1, 0, 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            n_vec++;
            if ({o_valid, o_reg_write, o_mem_read, o_operation, o_wr_addr, o_A, o_B} !==
                {1'b1, 1'b1, 1'b0, 4'b0011, 5'd12, 32'h40, 32'h50}) begin
                n_err++;
                $display("FAIL stall_hold cyc%0d got %b%b%b %h %0d %h %h exp 110 3 12 40 50",
                         k, o_valid, o_reg_write, o_mem_read, o_operation, o_wr_addr, o_A, o_B);
            end
        end
        i_stall = 0;
        idle_inputs();
    endtask

    task automatic test_async_reset();
        idle_inputs();
        drive_instr(32'h0, 32'h0, 32'h4, 5'd0, 5'd1, 5'd2, 5'd7, 4'b0000, 1, 1, 1);
        tick();
        drive_instr(32'h5, 32'h6, 32'h0, 5'd0, 5'd7, 5'd2, 5'd9, 4'b0000, 0, 1, 0);
        i_stall = 1;
        tick();
        rst = 0;
        #1;
        n_vec++; if ({o_valid, o_reg_write, o_mem_read, o_operation, o_wr_addr, o_stall_id} !== 13'd0) begin n_err++; $display("FAIL areset_ctrl got %b exp 0", {o_valid, o_reg_write, o_mem_read, o_operation, o_wr_addr, o_stall_id}); end
        n_vec++; if ({o_A, o_B, o_store_data} !== 96'd0) begin n_err++; $display("FAIL areset_data got %h %h %h exp 0", o_A, o_B, o_store_data); end
        #1;
        rst = 1;
        i_stall = 0;
        tick();
        n_vec++; if ({o_valid, o_A, o_wr_addr} !== {1'b1, 32'h5, 5'd9}) begin n_err++; $display("FAIL areset_load got %b %h %0d exp 1 5 9", o_valid, o_A, o_wr_addr); end
    endtask

    // Test sequence and summary
    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_add();
        test_shift_lui();
        test_forwarding();
        test_load_use();
        test_flush_stall();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
